// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: one downstream port serving NPORTS core ports
// plus a single-byte ROM loader buffer that always wins arbitration.
module mem_port_arbiter #(
    parameter int NPORTS    = 3,
    parameter int AW        = 25,
    parameter int DW        = 16,
    parameter int PRIO_MODE = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_active,
    input  logic [AW-1:0]        ld_addr,
    input  logic [7:0]           ld_data,
    input  logic                 ld_wr,
    output logic                 ld_busy,
    output logic                 ld_ovf,
    input  logic [NPORTS-1:0]    p_req,
    input  logic [NPORTS-1:0]    p_we,
    input  logic [NPORTS*AW-1:0] p_addr,
    input  logic [NPORTS*DW-1:0] p_wdata,
    output logic [NPORTS-1:0]    p_ack,
    output logic [DW-1:0]        p_rdata,
    output logic                 m_req,
    output logic                 m_we,
    output logic [AW-1:0]        m_addr,
    output logic [DW-1:0]        m_wdata,
    output logic [1:0]           m_be,
    input  logic                 m_done,
    input  logic [DW-1:0]        m_rdata
);

    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic          buf_full;
    logic [AW-1:0] buf_addr;
    logic [7:0]    buf_data;
    logic          gnt_loader;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] rr_ptr;

    logic          sel_valid;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] cand_idx;

    logic [AW-1:0] addr_arr  [NPORTS];
    logic [DW-1:0] wdata_arr [NPORTS];

    for (genvar g = 0; g < NPORTS; g++) begin : g_unpack
        assign addr_arr[g]  = p_addr[g*AW +: AW];
        assign wdata_arr[g] = p_wdata[g*DW +: DW];
    end

    assign ld_busy = buf_full;

    // Round-robin scans upward from the port after the last core grant;
    // fixed mode always scans from port 0.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            cand_idx = (PRIO_MODE == 1) ? IW'(i) : IW'((int'(rr_ptr) + 1 + i) % NPORTS);
            if (!sel_valid && p_req[cand_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            buf_full   <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            ld_ovf     <= 1'b0;
            gnt_loader <= 1'b0;
            gnt_idx    <= '0;
            rr_ptr     <= IW'(NPORTS - 1);
            p_ack      <= '0;
            p_rdata    <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_be       <= '0;
        end else begin
            // A strobe is dropped whenever the buffer is still full, including its clearing cycle.
            if (ld_wr) begin
                if (buf_full) begin
                    ld_ovf <= 1'b1;
                end else begin
                    buf_full <= 1'b1;
                    buf_addr <= ld_addr;
                    buf_data <= ld_data;
                end
            end

            p_ack <= '0;

            case (state)
                IDLE: begin
                    if (buf_full) begin
                        state      <= BUSY;
                        gnt_loader <= 1'b1;
                        m_req      <= 1'b1;
                        m_we       <= 1'b1;
                        m_addr     <= {buf_addr[AW-1:1], 1'b0};
                        m_wdata    <= {(DW/8){buf_data}};
                        m_be       <= buf_addr[0] ? 2'b10 : 2'b01;
                    end else if (!load_active && sel_valid) begin
                        state      <= BUSY;
                        gnt_loader <= 1'b0;
                        gnt_idx    <= sel_idx;
                        rr_ptr     <= sel_idx;
                        m_req      <= 1'b1;
                        m_we       <= p_we[sel_idx];
                        m_addr     <= addr_arr[sel_idx];
                        m_wdata    <= wdata_arr[sel_idx];
                        m_be       <= 2'b11;
                    end
                end
                BUSY: begin
                    if (m_done) begin
                        state <= RESP;
                        m_req <= 1'b0;
                        if (!gnt_loader) begin
                            p_ack[gnt_idx] <= 1'b1;
                            if (!m_we) begin
                                p_rdata <= m_rdata;
                            end
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (gnt_loader) begin
                        buf_full <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected downstream transactions and
// acks are queued as stimulus is driven and retired by negedge monitors.
module tb_mem_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 25;
    localparam int DW = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [1:0]    be;
    } xact_t;

    typedef struct packed {
        logic [NP-1:0] ack;
        logic          chk_rd;
        logic [DW-1:0] rdata;
    } ack_t;

    logic clk = 1'b0;
    logic reset;
    logic load_active, ld_wr, ld_busy, ld_ovf;
    logic [AW-1:0] ld_addr;
    logic [7:0] ld_data;
    logic [NP-1:0] p_req, p_we, p_ack;
    logic [NP*AW-1:0] p_addr;
    logic [NP*DW-1:0] p_wdata;
    logic [DW-1:0] p_rdata, m_wdata, m_rdata;
    logic m_req, m_we, m_done, done_r, stray_done;
    logic [AW-1:0] m_addr;
    logic [1:0] m_be;

    logic [NP-1:0] p_req_fx, p_ack_fx;
    logic [DW-1:0] p_rdata_fx, m_wdata_fx;
    logic [AW-1:0] m_addr_fx;
    logic [1:0] m_be_fx;
    logic m_req_fx, m_we_fx, done_fx, ld_busy_fx, ld_ovf_fx;

    xact_t xq[$];
    ack_t  aq[$];
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int ack_cyc = 0;
    int done_delay = 1;
    int busy_cnt = 0;
    logic [NP-1:0] drop_on_ack;
    logic m_req_d;

    assign m_done = done_r | stray_done;

    mem_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .PRIO_MODE(0)) dut (
        .clk(clk), .reset(reset), .load_active(load_active),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_wr(ld_wr),
        .ld_busy(ld_busy), .ld_ovf(ld_ovf),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ack(p_ack), .p_rdata(p_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_be(m_be), .m_done(m_done), .m_rdata(m_rdata)
    );

    mem_port_arbiter #(.NPORTS(NP), .AW(AW), .DW(DW), .PRIO_MODE(1)) dut_fx (
        .clk(clk), .reset(reset), .load_active(1'b0),
        .ld_addr('0), .ld_data(8'h00), .ld_wr(1'b0),
        .ld_busy(ld_busy_fx), .ld_ovf(ld_ovf_fx),
        .p_req(p_req_fx), .p_we('0), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_ack(p_ack_fx), .p_rdata(p_rdata_fx),
        .m_req(m_req_fx), .m_we(m_we_fx), .m_addr(m_addr_fx), .m_wdata(m_wdata_fx),
        .m_be(m_be_fx), .m_done(done_fx), .m_rdata(16'h0000)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_we[i] = we;
        p_addr[i*AW +: AW] = a;
        p_wdata[i*DW +: DW] = d;
    endtask

    task automatic push_core(input int i);
        xact_t x;
        ack_t a;
        x.addr = p_addr[i*AW +: AW];
        x.we = p_we[i];
        x.wdata = p_wdata[i*DW +: DW];
        x.be = 2'b11;
        a.ack = NP'(1) << i;
        a.chk_rd = !p_we[i];
        a.rdata = m_rdata;
        xq.push_back(x);
        aq.push_back(a);
    endtask

    task automatic push_loader(input logic [AW-1:0] a, input logic [7:0] d);
        xact_t x;
        x.addr = {a[AW-1:1], 1'b0};
        x.we = 1'b1;
        x.wdata = {d, d};
        x.be = a[0] ? 2'b10 : 2'b01;
        xq.push_back(x);
    endtask

    task automatic wait_mreq(input string tag);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (m_req) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (xq.size() == 0 && aq.size() == 0 && !m_req) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1'b1);
        tick();
        tick();
    endtask

    // Downstream memory model: m_done pulses done_delay cycles into each request.
    initial begin
        done_r = 1'b0;
        forever begin
            @(negedge clk);
            done_r = 1'b0;
            if (m_req) begin
                busy_cnt++;
                if (busy_cnt == done_delay) done_r = 1'b1;
            end else begin
                busy_cnt = 0;
            end
        end
    end

    initial begin
        done_fx = 1'b0;
        forever begin
            @(negedge clk);
            done_fx = m_req_fx && !done_fx;
        end
    end

    // Scoreboard monitor; ports flagged in drop_on_ack release their request on ack.
    initial begin
        xact_t x;
        ack_t a;
        m_req_d = 1'b0;
        forever begin
            @(negedge clk);
            if (m_req && !m_req_d) begin
                check("xact_pending", xq.size() != 0, 1'b1);
                if (xq.size() != 0) begin
                    x = xq.pop_front();
                    check("m_addr", m_addr, x.addr);
                    check("m_we", m_we, x.we);
                    check("m_wdata", m_wdata, x.wdata);
                    check("m_be", m_be, x.be);
                end
            end
            m_req_d = m_req;
            if (p_ack != '0) begin
                ack_cyc = cyc;
                ack_cnt++;
                check("ack_pending", aq.size() != 0, 1'b1);
                if (aq.size() != 0) begin
                    a = aq.pop_front();
                    check("p_ack", p_ack, a.ack);
                    if (a.chk_rd) check("p_rdata", p_rdata, a.rdata);
                end
                p_req = p_req & ~(p_ack & drop_on_ack);
            end
        end
    end

    initial begin
        int base, t0, fx_acks;
        logic ok;
        reset = 1'b1;
        load_active = 1'b0; ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
        p_req = '0; p_we = '0; p_addr = '0; p_wdata = '0;
        m_rdata = '0; stray_done = 1'b0; drop_on_ack = '0; p_req_fx = '0;
        tick();
        tick();
        check("rst_m_req", m_req, 1'b0);
        check("rst_m_addr", m_addr, '0);
        check("rst_m_wdata", m_wdata, '0);
        check("rst_m_be", m_be, 2'b00);
        check("rst_p_ack", p_ack, '0);
        check("rst_p_rdata", p_rdata, '0);
        check("rst_ld_busy", ld_busy, 1'b0);
        check("rst_ld_ovf", ld_ovf, 1'b0);
        reset = 1'b0;
        tick();

        // Round-robin with all ports held: grants 0,1,2,0.
        m_rdata = 16'hBEEF;
        set_port(0, 1'b1, 25'h000100, 16'h1000);
        set_port(1, 1'b0, 25'h000101, 16'h2000);
        set_port(2, 1'b1, 25'h000102, 16'h3000);
        push_core(0); push_core(1); push_core(2); push_core(0);
        p_req = 3'b111;
        base = ack_cnt;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (ack_cnt >= base + 4) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_rr", ok, 1'b1);
        p_req = '0;
        wait_done("tmo_rr_done");

        // Single read on port 0: ack lands in the third cycle counting the request cycle.
        m_rdata = 16'h1234;
        drop_on_ack = 3'b111;
        set_port(0, 1'b0, 25'h000055, 16'h0000);
        push_core(0);
        t0 = cyc;
        p_req[0] = 1'b1;
        wait_done("tmo_rd");
        check("lat", ack_cyc - t0, 2);
        check("rd_hold", p_rdata, 16'h1234);

        // Back-to-back loader strobes with slow memory: second is dropped.
        done_delay = 4;
        push_loader(25'h000005, 8'hA5);
        ld_wr = 1'b1; ld_addr = 25'h000005; ld_data = 8'hA5;
        tick();
        check("ld_busy_set", ld_busy, 1'b1);
        ld_addr = 25'h000022; ld_data = 8'h77;
        tick();
        ld_wr = 1'b0;
        check("ld_ovf_set", ld_ovf, 1'b1);
        wait_done("tmo_ld");
        check("ld_busy_clr", ld_busy, 1'b0);
        check("ld_ovf_sticky", ld_ovf, 1'b1);

        // Loader arriving mid-transaction beats a waiting core port.
        done_delay = 3;
        set_port(1, 1'b1, 25'h000111, 16'h1111);
        push_core(1);
        p_req[1] = 1'b1;
        wait_mreq("tmo_pr");
        set_port(2, 1'b1, 25'h000222, 16'h2222);
        push_loader(25'h000010, 8'h3C);
        push_core(2);
        ld_wr = 1'b1; ld_addr = 25'h000010; ld_data = 8'h3C;
        p_req[2] = 1'b1;
        tick();
        ld_wr = 1'b0;
        wait_done("tmo_pr_done");

        // load_active mid-transaction: in-flight ack still delivered, new grants blocked.
        set_port(0, 1'b1, 25'h0000AA, 16'h00AA);
        push_core(0);
        p_req[0] = 1'b1;
        wait_mreq("tmo_la");
        load_active = 1'b1;
        set_port(2, 1'b1, 25'h0002A2, 16'h2A2A);
        p_req[2] = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (aq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("tmo_la_ack", ok, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("la_block", m_req, 1'b0);
        end
        push_core(2);
        load_active = 1'b0;
        wait_done("tmo_la_done");

        // Stray m_done in IDLE must not produce an ack or a request.
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        check("stray_mreq", m_req, 1'b0);
        check("stray_ack", p_ack, '0);

        // Reset during BUSY abandons the transaction; next grant restarts at port 0.
        done_delay = 10;
        set_port(1, 1'b0, 25'h000133, 16'h0000);
        push_core(1);
        p_req[1] = 1'b1;
        wait_mreq("tmo_rst");
        reset = 1'b1;
        aq.delete();
        p_req = '0;
        #1;
        check("rst_async_mreq", m_req, 1'b0);
        tick();
        check("rst_ovf_clr", ld_ovf, 1'b0);
        reset = 1'b0;
        tick();
        check("rst_noack", p_ack, '0);
        done_delay = 1;
        m_rdata = 16'h5A5A;
        set_port(0, 1'b0, 25'h0000C0, 16'h0000);
        set_port(1, 1'b1, 25'h0001C0, 16'h1C1C);
        push_core(0); push_core(1);
        p_req = 3'b011;
        wait_done("tmo_post_rst");

        // Fixed priority with ports 1 and 2 held: port 1 served every time.
        p_req_fx = 3'b110;
        fx_acks = 0;
        for (int k = 0; k < 100 && fx_acks < 4; k++) begin
            tick();
            if (p_ack_fx != '0) begin
                check("fx_ack", p_ack_fx, 3'b010);
                fx_acks++;
            end
        end
        check("fx_count", fx_acks, 4);
        p_req_fx = '0;
        tick();
        tick();

        check("xq_empty", xq.size(), 0);
        check("aq_empty", aq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 3: number of core request ports (2..8).
REQ-002 SHALL have parameter AW, default 25: byte address width.
REQ-003 SHALL have parameter DW, default 16: memory data width (fixed two byte lanes).
REQ-004 SHALL have parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed (lowest index wins).
REQ-005 SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- load_active  in  1  ROM load in progress; core ports blocked
- ld_addr  in  AW  loader byte address
- ld_data  in  8  loader byte
- ld_wr  in  1  loader write strobe, one-cycle pulse
- ld_busy  out  1  loader holding buffer full
- ld_ovf  out  1  sticky: strobe arrived while buffer full
- p_req  in  NPORTS  per-port request level
- p_we  in  NPORTS  per-port write select
- p_addr  in  NPORTS*AW  per-port word address, port i at [i*AW +: AW]
- p_wdata  in  NPORTS*DW  per-port write data
- p_ack  out  NPORTS  one-hot completion pulse
- p_rdata  out  DW  read data, valid with p_ack
- m_req  out  1  downstream request level
- m_we  out  1  downstream write
- m_addr  out  AW  downstream word address
- m_wdata  out  DW  downstream write data
- m_be  out  2  byte enables
- m_done  in  1  downstream completion pulse
- m_rdata  in  DW  downstream read data, valid with m_done

Function
REQ-006 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-007 IDLE: if loader buffer full -> grant loader, go BUSY; else if load_active=0 and any p_req -> grant one port per PRIO_MODE, go BUSY; else stay.
REQ-008 Loader buffer SHALL have absolute priority over all core ports in both modes.
REQ-009 Round-robin: search starts at (last granted port + 1) mod NPORTS; last-grant pointer updates only on core-port grants.
REQ-010 BUSY: m_req=1 with m_we/m_addr/m_wdata/m_be registered at grant and stable until m_done; on m_done go RESP; m_req drops in the RESP cycle.
REQ-011 Core grant: m_be=2'b11, m_addr=p_addr of granted port, m_we=p_we, m_wdata=p_wdata.
REQ-012 Loader grant: m_we=1, m_addr=ld_addr with bit 0 cleared, m_wdata={ld_data,ld_data}, m_be=2'b01 if ld_addr[0]=0 else 2'b10.
REQ-013 RESP: for core grant, pulse p_ack[granted] for exactly one cycle; p_rdata = m_rdata captured on m_done (reads), held until next capture; return to IDLE. For loader grant, no p_ack; buffer cleared.
REQ-014 Latency: core grant in cycle after p_req seen in IDLE; p_ack one cycle after m_done. Minimum request-to-ack = 3 cycles with m_done in the first BUSY cycle.
REQ-015 Ports SHALL hold p_req, p_we, p_addr, p_wdata until p_ack; p_req still high in the cycle after p_ack is a new request.
REQ-016 Loader buffer: ld_wr with buffer empty captures ld_addr/ld_data, sets ld_busy next cycle.
REQ-017 ld_wr with buffer full (including the cycle it clears) SHALL be dropped and set ld_ovf; ld_ovf clears only on reset.
REQ-018 load_active rising during BUSY SHALL NOT abort the transaction in flight; ack delivered normally.
REQ-019 m_done outside BUSY SHALL be ignored.
REQ-020 Only one transaction outstanding downstream at any time.

Reset
REQ-021 On reset: state IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, m_be=0, p_ack=0, p_rdata=0, ld_busy=0, ld_ovf=0, buffer empty, round-robin pointer = NPORTS-1 (port 0 first).
REQ-022 Reset asserted mid-transaction SHALL abandon it immediately; no p_ack after release.

Verification
REQ-023 Round-robin, NPORTS=3, all p_req held, m_done 1 cycle after m_req -> grants 0,1,2,0; one p_ack per transaction.
REQ-024 PRIO_MODE=1, p_req=3'b110 held -> port 1 served repeatedly, port 2 starved.
REQ-025 ld_wr addr=0x000005 data=0xA5 -> m_addr=0x000004, m_wdata=0xA5A5, m_be=2'b10, m_we=1; no p_ack.
REQ-026 Two ld_wr in consecutive cycles with m_done delayed 4 cycles -> second dropped, ld_ovf=1 and stays 1.
REQ-027 Port 0 read, m_rdata=0x1234 with m_done -> next cycle p_ack=3'b001, p_rdata=0x1234.
REQ-028 reset pulse during BUSY -> m_req=0 asynchronously, no p_ack after release, next grant port 0.
